// File: rtl/rfa_pkg.sv
// Shared constants and helpers for the register-file-access arbiter.
// Channel map: SIMD units occupy channels 0-3, SIMF units channels 4-7.
package rfa_pkg;

   localparam int RFA_NUM_REQ      = 8;
   localparam int RFA_SEL_WIDTH    = 16;
   localparam int RFA_SEL_BASE     = 0;
   localparam int RFA_STARVE_LIMIT = 15;
   localparam int RFA_CNT_W        = 8;
   localparam int RFA_MAX_REQ      = 16;

   localparam int SIMD0 = 0;
   localparam int SIMD1 = 1;
   localparam int SIMD2 = 2;
   localparam int SIMD3 = 3;
   localparam int SIMF0 = 4;
   localparam int SIMF1 = 5;
   localparam int SIMF2 = 6;
   localparam int SIMF3 = 7;

   // OR-reduction encoder; the result is only meaningful for a one-hot input.
   function automatic logic [3:0] onehot_to_idx(input logic [RFA_MAX_REQ-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < RFA_MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rfa_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
// With ptr_i tied to zero it degenerates into a lowest-index-first picker.
module rfa_rr_pick
   import rfa_pkg::*;
#(
   parameter int N = 8,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [PTR_W-1:0] gnt_idx_o,
   output logic             any_o
);

   int               j;
   logic [PTR_W-1:0] jj;

   // Scan offsets from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      gnt_oh_o = '0;
      j        = 0;
      jj       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j  = (int'(ptr_i) + k) % N;
         jj = PTR_W'(j);
         if (req_i[jj]) begin
            gnt_oh_o     = '0;
            gnt_oh_o[jj] = 1'b1;
         end
      end
   end

   assign any_o     = |req_i;
   assign gnt_idx_o = PTR_W'(onehot_to_idx(RFA_MAX_REQ'(gnt_oh_o)));

endmodule

// File: rtl/rfa_rr_arbiter.sv
// Round-robin arbiter for the shared VGPR/SGPR read port with double-width
// ops, external stall and per-channel starvation override.
module rfa_rr_arbiter
   import rfa_pkg::*;
#(
   parameter int NUM_REQ      = RFA_NUM_REQ,
   parameter int SEL_WIDTH    = RFA_SEL_WIDTH,
   parameter int SEL_BASE     = RFA_SEL_BASE,
   parameter int STARVE_LIMIT = RFA_STARVE_LIMIT,
   parameter int CNT_W        = RFA_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_double,
   input  logic                 ext_stall,
   output logic [NUM_REQ-1:0]   req_serviced,
   output logic [SEL_WIDTH-1:0] execvgprsgpr_select_fu,
   output logic                 port_busy,
   output logic                 starve_active
);

   localparam int             PTR_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             busy_q, busy_d;
   logic [PTR_W-1:0] busy_ch_q, busy_ch_d;
   logic [CNT_W-1:0] wait_cnt_q [NUM_REQ];
   logic [CNT_W-1:0] wait_cnt_d [NUM_REQ];

   logic [NUM_REQ-1:0] starved;
   logic [NUM_REQ-1:0] rr_oh, st_oh, gnt_oh, owner_oh;
   logic [PTR_W-1:0]   rr_idx, st_idx, gnt_idx;
   logic               rr_any, st_any, grant;

   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         starved[i] = req_valid[i] && (wait_cnt_q[i] >= LIMIT);
      end
   end

   rfa_rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (rr_oh),
      .gnt_idx_o (rr_idx),
      .any_o     (rr_any)
   );

   rfa_rr_pick #(.N(NUM_REQ)) u_starve_pick (
      .req_i     (starved),
      .ptr_i     ('0),
      .gnt_oh_o  (st_oh),
      .gnt_idx_o (st_idx),
      .any_o     (st_any)
   );

   // The busy cycle keeps the port for the double op regardless of ext_stall.
   always_comb begin
      grant    = !busy_q && !ext_stall && rr_any;
      gnt_oh   = st_any ? st_oh : rr_oh;
      gnt_idx  = st_any ? st_idx : rr_idx;
      owner_oh = '0;
      if (busy_q) begin
         owner_oh = NUM_REQ'(1) << busy_ch_q;
      end else if (grant) begin
         owner_oh = gnt_oh;
      end
   end

   always_comb begin
      req_serviced           = '0;
      execvgprsgpr_select_fu = '0;
      port_busy              = 1'b0;
      starve_active          = 1'b0;
      if (!rst) begin
         req_serviced                                = grant ? gnt_oh : '0;
         execvgprsgpr_select_fu[SEL_BASE +: NUM_REQ] = owner_oh;
         port_busy                                   = busy_q;
         starve_active                               = grant && st_any;
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      busy_d    = 1'b0;
      busy_ch_d = busy_ch_q;
      if (grant) begin
         rr_ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
         busy_d    = req_double[gnt_idx];
         busy_ch_d = gnt_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!req_valid[i] || (grant && gnt_oh[i])) begin
            wait_cnt_d[i] = '0;
         end else if (wait_cnt_q[i] >= LIMIT) begin
            wait_cnt_d[i] = LIMIT;
         end else begin
            wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      end
      busy_ch_q <= busy_ch_d;
   end

endmodule

// File: tb/tb_rfa_rr_arbiter.sv
// Bench for rfa_rr_arbiter: two instances (default and short-starvation with
// an offset select base) checked every cycle against a rule-level model.
module tb_rfa_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ext_stall = 1'b0;
   logic [7:0]  req_valid = '0;
   logic [7:0]  req_double = '0;

   logic [7:0]  serv_a, serv_b;
   logic [15:0] sel_a, sel_b;
   logic        pb_a, pb_b, st_a, st_b;

   int tests = 0;
   int fails = 0;

   int m_rr   [2];
   bit m_busy [2];
   int m_bch  [2];
   int m_wc   [2][8];
   int lim    [2] = '{15, 4};
   int base   [2] = '{0, 8};

   logic [7:0] mv_valid  [16] = '{8'hFF, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h0F, 8'h81, 8'h81,
                                  8'h81, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 8'hFF};
   logic [7:0] mv_double [16] = '{8'h00, 8'h30, 8'h30, 8'h0F, 8'h0F, 8'h0F, 8'h80, 8'h80,
                                  8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'hFF, 8'hFF};
   logic       mv_stall  [16] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

   always #5 clk = ~clk;

   rfa_rr_arbiter dut_a (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_double             (req_double),
      .ext_stall              (ext_stall),
      .req_serviced           (serv_a),
      .execvgprsgpr_select_fu (sel_a),
      .port_busy              (pb_a),
      .starve_active          (st_a)
   );

   rfa_rr_arbiter #(
      .NUM_REQ(8), .SEL_WIDTH(16), .SEL_BASE(8), .STARVE_LIMIT(4), .CNT_W(8)
   ) dut_b (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_double             (req_double),
      .ext_stall              (ext_stall),
      .req_serviced           (serv_b),
      .execvgprsgpr_select_fu (sel_b),
      .port_busy              (pb_b),
      .starve_active          (st_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: expected outputs for this cycle, then advance to the post-edge state.
   task automatic model_step(input int n);
      logic [7:0]  e_serv;
      logic [15:0] e_sel;
      logic        e_pb, e_st;
      int          g, c;
      e_serv = '0; e_sel = '0; e_pb = 1'b0; e_st = 1'b0; g = -1;
      if (rst) begin
         m_rr[n] = 0;
         m_busy[n] = 0;
         for (int i = 0; i < 8; i++) m_wc[n][i] = 0;
      end else begin
         if (m_busy[n]) begin
            e_sel = 16'(1) << (base[n] + m_bch[n]);
            e_pb  = 1'b1;
         end else if (!ext_stall && req_valid != 0) begin
            for (int i = 0; i < 8 && g < 0; i++) begin
               if (req_valid[i] && m_wc[n][i] >= lim[n]) begin
                  g = i;
                  e_st = 1'b1;
               end
            end
            for (int k = 0; k < 8 && g < 0; k++) begin
               c = (m_rr[n] + k) % 8;
               if (req_valid[c]) g = c;
            end
            e_serv = 8'(1) << g;
            e_sel  = 16'(1) << (base[n] + g);
         end
         for (int i = 0; i < 8; i++) begin
            if (!req_valid[i] || i == g) m_wc[n][i] = 0;
            else m_wc[n][i] = (m_wc[n][i] + 1 > lim[n]) ? lim[n] : m_wc[n][i] + 1;
         end
         m_busy[n] = 1'b0;
         if (g >= 0) begin
            m_busy[n] = req_double[g];
            m_bch[n]  = g;
            m_rr[n]   = (g + 1) % 8;
         end
      end
      chk($sformatf("i%0d.serviced", n), (n == 0) ? serv_a : serv_b, e_serv);
      chk($sformatf("i%0d.select", n), (n == 0) ? sel_a : sel_b, e_sel);
      chk($sformatf("i%0d.port_busy", n), (n == 0) ? pb_a : pb_b, e_pb);
      chk($sformatf("i%0d.starve", n), (n == 0) ? st_a : st_b, e_st);
   endtask

   always @(negedge clk) begin
      for (int n = 0; n < 2; n++) model_step(n);
   end

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_double = '0; ext_stall = 1'b0;
      smp();
      nxt();
      rst = 1'b0;
   endtask

   logic [7:0] sparse_exp [8] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02, 8'h08, 8'h20, 8'h80};

   initial begin
      // Reset holds outputs low even with every queue requesting.
      rst = 1'b1; req_valid = 8'hFF;
      smp();
      chk("reset_serv", serv_a, 8'h00);
      chk("reset_sel_b", sel_b, 16'h0000);
      nxt();
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         smp();
         chk($sformatf("rot%0d_serv", k), serv_a, 8'(1) << (k % 8));
         chk($sformatf("rot%0d_sel", k), sel_a, 16'(1) << (k % 8));
         chk($sformatf("rot%0d_starve", k), st_a, 1'b0);
         nxt();
      end

      ext_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("stall_serv", serv_a, 8'h00);
         chk("stall_sel", sel_a, 16'h0000);
         nxt();
      end
      ext_stall = 1'b0;
      smp();
      chk("stall_resume", serv_a, 8'h04);
      nxt();

      do_reset();
      req_valid = 8'hAA;
      for (int k = 0; k < 8; k++) begin
         smp();
         chk($sformatf("sparse%0d", k), serv_a, sparse_exp[k]);
         nxt();
      end
      req_valid = 8'h05;
      smp();
      chk("sparse_wrap", serv_a, 8'h01);
      nxt();

      do_reset();
      req_valid = 8'h08; req_double = 8'h08;
      smp();
      chk("dbl_t0_serv", serv_a, 8'h08);
      chk("dbl_t0_sel", sel_a, 16'h0008);
      nxt();
      req_valid = 8'h01; req_double = 8'h00; ext_stall = 1'b1;
      smp();
      chk("dbl_t1_serv", serv_a, 8'h00);
      chk("dbl_t1_sel", sel_a, 16'h0008);
      chk("dbl_t1_busy", pb_a, 1'b1);
      nxt();
      ext_stall = 1'b0;
      smp();
      chk("dbl_t2_serv", serv_a, 8'h01);
      nxt();

      do_reset();
      req_valid = 8'h40;
      smp();
      chk("stv_setup", serv_b, 8'h40);
      nxt();
      ext_stall = 1'b1;
      for (int c = 0; c < 6; c++) begin
         req_valid = (c >= 3) ? 8'h42 : 8'h40;
         smp();
         nxt();
      end
      ext_stall = 1'b0; req_valid = 8'h42;
      smp();
      chk("stv_c6_serv_b", serv_b, 8'h40);
      chk("stv_c6_starve_b", st_b, 1'b1);
      chk("stv_c6_sel_b", sel_b, 16'h4000);
      chk("stv_c6_serv_a", serv_a, 8'h02);
      chk("stv_c6_starve_a", st_a, 1'b0);
      nxt();
      req_valid = 8'h02;
      smp();
      chk("stv_c7_serv_b", serv_b, 8'h02);
      nxt();

      for (int k = 0; k < 16; k++) begin
         req_valid = mv_valid[k]; req_double = mv_double[k]; ext_stall = mv_stall[k];
         smp();
         nxt();
      end

      do_reset();
      req_valid = 8'h20; req_double = 8'h20;
      smp();
      chk("rmb_grant", serv_a, 8'h20);
      nxt();
      rst = 1'b1; req_valid = 8'h00; req_double = 8'h00;
      smp();
      chk("rmb_rst_sel", sel_a, 16'h0000);
      chk("rmb_rst_busy", pb_a, 1'b0);
      nxt();
      rst = 1'b0;
      smp();
      chk("rmb_idle_sel", sel_a, 16'h0000);
      chk("rmb_idle_busy", pb_a, 1'b0);
      nxt();
      req_valid = 8'hFF;
      smp();
      chk("rmb_first", serv_a, 8'h01);
      nxt();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rfa_rr_arbiter.md
Name: rfa_rr_arbiter

Overview:
- Parametrised register-file-access arbiter: grants the single shared VGPR/SGPR read port to one of NUM_REQ functional-unit issue queues (default 8: simd0-3 on channels 0-3, simf0-3 on channels 4-7) per cycle.
- Successor to the fixed 8-queue rfa. Adds:
  - a configurable channel count and select-bus mapping;
  - round-robin fairness;
  - two-cycle (double-width) operations that occupy the port;
  - an external stall;
  - starvation-override counters.

Parameters:
- NUM_REQ, 8: number of requesting queues (2..16).
- SEL_WIDTH, 16: width of execvgprsgpr_select_fu.
- SEL_BASE, 0: select bit driven for channel 0. Channel i drives bit SEL_BASE+i. SEL_BASE+NUM_REQ <= SEL_WIDTH.
- STARVE_LIMIT, 15: wait cycles after which a channel overrides round-robin (1..255).
- CNT_W, 8: starvation counter width (2^CNT_W > STARVE_LIMIT).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-queue entry valid. Held until serviced.
- req_double  in  NUM_REQ  per-queue flag: the op needs the port for 2 cycles. Qualified by req_valid.
- ext_stall  in  1  port taken externally (LSU/debug); blocks new grants.
- req_serviced  out  NUM_REQ  one-hot grant pulse; queue pops its entry on the following edge.
- execvgprsgpr_select_fu  out  SEL_WIDTH  one-hot port owner select.
- port_busy  out  1  high during the second cycle of a double op.
- starve_active  out  1  the current grant came from starvation override.

Behaviour:
- State (registered):
  - rr_ptr, $clog2(NUM_REQ) bits;
  - busy flag;
  - busy_ch;
  - wait_cnt[NUM_REQ], each CNT_W bits.
- Grant logic is combinational from req_valid, ext_stall and the state. There is no request-to-grant latency: req_serviced is asserted in the same cycle as the valid.
- Reset (rst=1 at an edge): rr_ptr=0, busy=0, all wait_cnt=0. While rst is high, all outputs are forced to 0.
- Grant eligible (elig) when busy=0 and ext_stall=0 and req_valid != 0. Otherwise req_serviced=0.
- Selection:
  - If any valid channel has wait_cnt >= STARVE_LIMIT, the lowest-index such channel wins and starve_active=1.
  - Else round-robin: the first valid channel scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- On a grant to channel g:
  - req_serviced[g]=1 and select bit SEL_BASE+g = 1.
  - Next rr_ptr = (g+1) mod NUM_REQ; wraps from NUM_REQ-1 to 0.
  - wait_cnt[g] is cleared.
  - If req_double[g]=1: busy<=1 and busy_ch<=g.
- Busy cycle (busy=1):
  - select bit SEL_BASE+busy_ch held at 1, port_busy=1, req_serviced=0, no grant;
  - busy<=0 at the end of the cycle.
  - ext_stall is ignored during the busy cycle: the in-flight op completes.
- Idle or stall cycle: execvgprsgpr_select_fu=0, starve_active=0. rr_ptr is unchanged.
- wait_cnt[i] update each cycle:
  - cleared when req_valid[i]=0 or channel i is granted;
  - otherwise incremented, saturating at STARVE_LIMIT.
  - It counts during stall and busy cycles as well.
- Simultaneous events:
  - A starved channel beats the round-robin choice.
  - Among several starved channels, the lowest index wins.
  - After a starvation grant, rr_ptr still advances to g+1.
- Invariants:
  - A queue that drops valid without being serviced is legal: its counter clears and it is never granted while invalid.
  - Bits of execvgprsgpr_select_fu outside [SEL_BASE, SEL_BASE+NUM_REQ) are always 0.
  - req_serviced and execvgprsgpr_select_fu are never multi-hot.
- Reset mid-operation: rst during the busy cycle aborts it. The next cycle after reset is idle-capable with rr_ptr=0.

Decomposition:
- Shared package rfa_pkg:
  - default NUM_REQ/SEL_WIDTH/SEL_BASE/STARVE_LIMIT constants;
  - the channel-to-FU index constants (SIMD0..SIMF3);
  - a function for the one-hot-to-index conversion.
- One natural sub-module, rfa_rr_pick: a combinational rotate-priority picker (request vector plus pointer in, one-hot plus index out). It is used for the round-robin path; the starvation path reuses it with pointer 0.

Test Plan:
- Round-robin rotation: NUM_REQ=8, req_valid=0xFF held 10 cycles after reset -> req_serviced 0x01,0x02,0x04,...,0x80,0x01,0x02; select_fu bit i tracks the grant; starve_active=0.
- Sparse mask: req_valid=0xAA held -> grants 0x02,0x08,0x20,0x80,0x02. Then the mask changes to 0x05 right after the ch7 grant -> next grant 0x01 (rr_ptr wrapped to 0).
- Double op: only ch3 valid with req_double=1; ch0 valid from the next cycle.
  - Cycle t: serviced=0x08, select bit 3.
  - Cycle t+1: serviced=0x00, select bit 3 still 1, port_busy=1.
  - Cycle t+2: serviced=0x01.
- Starvation override: STARVE_LIMIT=4, rr_ptr=7 after a ch6 grant. ch6 valid from cycle 0, ch1 valid from cycle 3, ext_stall=1 for cycles 0-5.
  - Cycle 6: serviced=0x40 (wait_cnt[6]=4 beats the round-robin choice of ch1), starve_active=1.
  - Cycle 7: serviced=0x02.
- Stall: ext_stall=1 with req_valid=0xFF for 3 cycles -> req_serviced=0 and select_fu=0 throughout; grants resume at the unchanged rr_ptr.
- Reset mid-busy: assert rst in the busy cycle of a ch5 double op -> next cycle all outputs 0; after release with req_valid=0xFF, the first grant is 0x01.
